imm_ext_fifo: RTL
=================

IMM_EXT_FIFO -- requirements
Module: imm_ext_fifo

Interface
REQ-001 Parameter DATA_W, default 64: immediate output width; legal values 32..64.
REQ-002 Parameter DEPTH, default 2: output buffer entries; legal values 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  instruction word and format are valid.
REQ-006 in_ready  output  1  block can accept an entry this cycle.
REQ-007 instr  input  32  LEGv8 instruction word.
REQ-008 fmt  input  3  immediate format select (see REQ-012).
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 imm  output  DATA_W  extended immediate of the head entry.
REQ-011a err  output  1  head entry came from an illegal fmt.
REQ-011b count  output  $clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-012 The extend result SHALL be computed combinationally from instr/fmt:
- fmt 0, I: instr[21:10] zero-extended.
- fmt 1, D: instr[20:12] sign-extended from bit 8.
- fmt 2, B: instr[25:0] sign-extended from bit 25, then shifted left 2.
- fmt 3, CB: instr[23:5] sign-extended from bit 18, then shifted left 2.
- fmt 4, IW: instr[20:5] zero-extended, then shifted left 16*instr[22:21].
- fmt 5-7: result 0, err=1.
- For fmt 0-4, err=0.
REQ-013 Results SHALL be formed at 64 bits, then truncated to the low DATA_W bits; sign is replicated up to bit 63 before truncation.
REQ-014 An entry is accepted when in_valid && in_ready at a rising edge; the result and err SHALL be written into a DEPTH-entry FIFO.
REQ-015 An entry is consumed when out_valid && out_ready at a rising edge.
REQ-016 in_ready SHALL be (count < DEPTH), driven from registered state only; there is no combinational path from out_ready.
REQ-017 out_valid SHALL be (count != 0); imm and err SHALL present the head entry, driven from registers.
REQ-018 Latency: an entry accepted at edge N into an empty FIFO SHALL appear on out_valid/imm after edge N, i.e. in cycle N+1.
REQ-019 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated.
REQ-020 Simultaneous accept and consume:
- count unchanged.
- Both pointers advance.
- Legal when 0 < count < DEPTH.
REQ-021 When full, in_ready SHALL be 0 even if out_ready=1; after the consume edge, count=DEPTH-1 and in_ready=1.
REQ-022 When empty, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH, including non-power-of-2 DEPTH.
REQ-024 In_valid without in_ready SHALL cause no state change; instr/fmt may change freely while in_valid=0.
REQ-025 When out_valid=1 and out_ready=0, imm and err SHALL hold stable.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk:
- clear count and both pointers;
- force out_valid=0, imm=0, err=0;
- leave in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries; there is no handshake on reset-edge cycles.
REQ-028 The first accept SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-029 D-type sign extension: fmt=1, instr[20:12]=9'h1FC, out_ready=1 -> next cycle imm=64'hFFFF_FFFF_FFFF_FFFC, err=0.
REQ-030 B-type and IW-type:
- fmt=2, instr[25:0]=26'h3FF_FFFF -> imm=64'hFFFF_FFFF_FFFF_FFFC.
- fmt=4, instr[20:5]=16'hBEEF, instr[22:21]=2 -> imm=64'h0000_BEEF_0000_0000.
REQ-031 Backpressure: DEPTH=2, out_ready=0, push I imm 5, then 7, then 9.
- After two accepts, in_ready=0 and count=2.
- The third word is not accepted.
- Raise out_ready -> 5 then 7 drain in order; the third word is accepted once in_ready returns to 1.
REQ-032 Streaming: continuous in_valid=1/out_ready=1 for 20 random words -> one output per cycle after 1-cycle latency, matches reference model, count stays 1.
REQ-033 Illegal fmt=6 -> imm=0, err=1; the next legal entry has err=0.
REQ-034 Reset mid-stream: fill 2 entries, pulse reset between edges -> out_valid=0 and count=0 asynchronously; no stale entry emerges afterward.
REQ-035 DATA_W=32: fmt=2, instr[25:0]=26'h200_0000 -> imm=32'hF800_0000.

Source files
------------

// File: rtl/imm_ext_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : imm_ext_fifo                                                  |
// | Purpose  : LEGv8 immediate extender feeding a DEPTH-entry output FIFO.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module imm_ext_fifo #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [2:0]        fmt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm,
   output logic              err,
   output logic [CNT_W-1:0]  count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [63:0]       ext_full;
   logic              ext_err;
   logic [5:0]        iw_shift;
   logic              push;
   logic              pop;
   logic              unused_bits;

   logic [DATA_W:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_ONE;
   endfunction

   // Every format is built at full 64-bit width; truncation happens on write.
   always_comb begin
      ext_full = '0;
      ext_err  = 1'b0;
      iw_shift = {instr[22:21], 4'b0000};
      case (fmt)
         3'd0:    ext_full = {52'd0, instr[21:10]};
         3'd1:    ext_full = {{55{instr[20]}}, instr[20:12]};
         3'd2:    ext_full = {{36{instr[25]}}, instr[25:0], 2'b00};
         3'd3:    ext_full = {{43{instr[23]}}, instr[23:5], 2'b00};
         3'd4:    ext_full = {48'd0, instr[20:5]} << iw_shift;
         default: ext_err  = 1'b1;
      endcase
   end

   assign unused_bits = ^{instr[31:26], ext_full};

   assign in_ready  = (count_q < FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Gating with out_valid makes imm/err read zero straight out of reset.
   assign {err, imm} = out_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {ext_err, ext_full[DATA_W-1:0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire
